wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage. Produces the single register-file write port (wb_rd, wb_write_data, wb_reg_write) consumed by the decode stage.
- Merges two result sources:
  - the in-order MEM/WB pipeline result (ALU result or extracted load data);
  - out-of-order completions from the multi-cycle FPU, buffered in a small FIFO.
- Exports a pending-register mask so decode can stall on RAW hazards against queued FPU results.

Parameters:
- BUS_WIDTH, 64, data width.
- REGFILE_LEN, 6, register address width; bit 5 = FP bank.
- FIFO_DEPTH, 4, FPU result queue entries (power of two, ≥2).
- FUNCT3_WIDTH, 3, load size/sign code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_valid  in  1  pipeline slot holds an instruction.
- mem_reg_write  in  1  instruction writes a register.
- mem_to_reg  in  1  1 = load data, 0 = ALU result.
- mem_funct3  in  3  load size/sign code.
- mem_addr_lo  in  3  byte offset of load address.
- mem_rd  in  REGFILE_LEN  destination register.
- mem_alu_result  in  BUS_WIDTH  ALU/FPU-bypass result.
- mem_read_data  in  BUS_WIDTH  aligned doubleword from data memory.
- fpu_valid  in  1  FPU result available.
- fpu_ready  out  1  queue can accept this cycle.
- fpu_rd  in  REGFILE_LEN  FPU destination.
- fpu_result  in  BUS_WIDTH  FPU result.
- wb_reg_write  out  1  register write enable.
- wb_rd  out  REGFILE_LEN  write address.
- wb_write_data  out  BUS_WIDTH  write data.
- pending_mask  out  2^REGFILE_LEN  bit r = 1 if r has a queued FPU result.
- fifo_empty  out  1  queue drained (used for fence/halt).

Behaviour:
- **Reset:** while rst_n=0 at a clock edge:
  - wb_reg_write=0, wb_rd=0, wb_write_data=0;
  - FIFO pointers and count = 0, so fifo_empty=1, fpu_ready=1, pending_mask=0.
  - Reset mid-operation discards all queued FPU results.
- **Outputs:** wb_* are registered; latency is exactly 1 cycle from selection to write port.
- **Pipeline request:** pipe_req = mem_valid & mem_reg_write. The pipeline always has priority and is never stalled by this block.
- **Selection each cycle:**
  - If pipe_req: write mem_rd with pipe data.
  - Else if FIFO non-empty: pop head and write it.
  - Else: wb_reg_write=0 and wb_rd/wb_write_data hold their previous values.
- **x0 suppression:** a selected write with rd == 6'b000000 is issued with wb_reg_write=0. It still consumes the slot and still pops the FIFO. FP f0 (6'b100000) writes normally.
- **Load extraction (mem_to_reg=1):**
  - Select the byte/half/word at mem_addr_lo.
  - Codes: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Sign- or zero-extend to BUS_WIDTH according to the code.
  - 010 with mem_rd[5]=1 (flw): NaN-box, i.e. upper 32 bits all ones.
  - Misaligned offsets are not checked; the low bits are used as given.
  - Code 111: data = 0.
- **FIFO handshake:**
  - fpu_ready = (count < FIFO_DEPTH), a registered-state function only, with no combinational path from fpu_valid.
  - Push when fpu_valid & fpu_ready.
  - Same-cycle push and pop: count unchanged, both pointers advance.
  - Push while empty and no pipe_req: the entry is written on the next cycle, not bypassed.
  - Full: fpu_ready=0; the FPU holds its result.
- **Pointer width:** pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- **pending_mask:** OR over valid entries of onehot(rd). It is combinational from FIFO state and covers duplicates. A bit clears the cycle after its last entry pops.
- **Ordering:** FPU results to the same rd retire in arrival order.

Decomposition:
- Shared package holds:
  - load funct3 encodings (LB..LWU);
  - FP-bank bit index (REGFILE_LEN-1);
  - NAN_BOX constant 32'hFFFF_FFFF.
- One sub-module: wb_result_fifo (synchronous FIFO with count and per-entry valid/rd exposure for the pending mask).
- Load extraction stays inline as a combinational function.

Test Plan:
1. **Reset mid-operation:** push 3 FPU results (rd=6'h21,6'h22,6'h23), then assert rst_n=0 for 1 cycle → fifo_empty=1, pending_mask=0, wb_reg_write=0, fpu_ready=1.
2. **Load extraction:** mem_read_data=64'h8877_6655_4433_2211, mem_addr_lo=3:
   - lb → 64'h0000_0000_0000_0044;
   - funct3=001 with offset 6 → 64'hFFFF_FFFF_FFFF_8877;
   - flw to rd=6'h25 at offset 4 → 64'hFFFF_FFFF_8877_6655.
3. **Priority:** continuous pipe_req writes for 5 cycles while the FPU pushes 4 results → fpu_ready falls to 0 after the 4th push. No FPU write appears until pipe_req drops, then results retire in push order, one per cycle.
4. **Simultaneous push/pop:** count=2, no pipe_req, push → count stays 2. Head (rd=6'h30) is written next cycle; pending_mask bit 0x30 clears.
5. **x0 suppression:** pipe write rd=0 → wb_reg_write=0. FPU result rd=6'h20 popped → wb_reg_write=1, wb_rd=6'h20.
6. **Duplicate rd:** two queued results for rd=6'h28 (A then B) → pending bit stays 1 until B pops; the final write data is B.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load size codes, FP bank
// select bit and the NaN-box pattern used for single-precision FP loads.
package wb_stage_pkg;

  localparam int REGFILE_LEN_DEF = 6;
  localparam int FP_BANK_BIT     = REGFILE_LEN_DEF - 1;

  localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    LB   = 3'b000,
    LH   = 3'b001,
    LW   = 3'b010,
    LD   = 3'b011,
    LBU  = 3'b100,
    LHU  = 3'b101,
    LWU  = 3'b110,
    LRSV = 3'b111
  } load_f3_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous queue for out-of-order FPU results. Exposes the occupancy and
// each entry's valid bit and destination so the stage can build a hazard mask.
module wb_result_fifo
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_W   = 6,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [RD_W-1:0]           i_push_rd,
  input  logic [DATA_W-1:0]         i_push_data,
  output logic [RD_W-1:0]           o_head_rd,
  output logic [DATA_W-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_empty,
  output logic [DEPTH-1:0]          o_entry_valid,
  output logic [DEPTH*RD_W-1:0]     o_entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [RD_W-1:0]   r_rd   [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pop clears before push sets so the newer write wins on a shared slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_valid  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= {DATA_W{1'b0}};
        r_rd[i]   <= {RD_W{1'b0}};
      end
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1'b1);
      end
      if (i_push) begin
        r_data[r_wr_ptr]  <= i_push_data;
        r_rd[r_wr_ptr]    <= i_push_rd;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1'b1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_entry_rd = {(DEPTH*RD_W){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_rd[i*RD_W +: RD_W] = r_rd[i];
    end
  end

  assign o_head_rd     = r_rd[r_rd_ptr];
  assign o_head_data   = r_data[r_rd_ptr];
  assign o_count       = r_count;
  assign o_empty       = (r_count == {CNT_W{1'b0}});
  assign o_entry_valid = r_valid;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges in-order pipeline results with queued FPU results
// onto the single register-file write port; the pipeline always wins.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int REGFILE_LEN  = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write,
  input  logic                      mem_to_reg,
  input  logic [FUNCT3_WIDTH-1:0]   mem_funct3,
  input  logic [2:0]                mem_addr_lo,
  input  logic [REGFILE_LEN-1:0]    mem_rd,
  input  logic [BUS_WIDTH-1:0]      mem_alu_result,
  input  logic [BUS_WIDTH-1:0]      mem_read_data,
  input  logic                      fpu_valid,
  output logic                      fpu_ready,
  input  logic [REGFILE_LEN-1:0]    fpu_rd,
  input  logic [BUS_WIDTH-1:0]      fpu_result,
  output logic                      wb_reg_write,
  output logic [REGFILE_LEN-1:0]    wb_rd,
  output logic [BUS_WIDTH-1:0]      wb_write_data,
  output logic [2**REGFILE_LEN-1:0] pending_mask,
  output logic                      fifo_empty
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PM_W  = 2**REGFILE_LEN;

  logic                          w_pipe_req;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_empty;
  logic [CNT_W-1:0]              w_count;
  logic [REGFILE_LEN-1:0]        w_head_rd;
  logic [BUS_WIDTH-1:0]          w_head_data;
  logic [FIFO_DEPTH-1:0]         w_entry_valid;
  logic [FIFO_DEPTH*REGFILE_LEN-1:0] w_entry_rd;
  logic                          w_sel;
  logic [REGFILE_LEN-1:0]        w_sel_rd;
  logic [BUS_WIDTH-1:0]          w_sel_data;
  logic [PM_W-1:0]               w_pending;

  logic                          r_wb_reg_write;
  logic [REGFILE_LEN-1:0]        r_wb_rd;
  logic [BUS_WIDTH-1:0]          r_wb_data;

  // Misaligned offsets are deliberately not trapped; the shifted low bits are used as-is.
  function automatic logic [BUS_WIDTH-1:0] f_load_extract(
    input logic [2:0]           f3,
    input logic [2:0]           off,
    input logic                 is_fp,
    input logic [BUS_WIDTH-1:0] dw
  );
    logic [BUS_WIDTH-1:0] sh;
    logic [BUS_WIDTH-1:0] res;
    sh = dw >> {off, 3'b000};
    case (load_f3_e'(f3))
      LB:  res = {{(BUS_WIDTH-8){sh[7]}}, sh[7:0]};
      LH:  res = {{(BUS_WIDTH-16){sh[15]}}, sh[15:0]};
      LW: begin
        if (is_fp) res = {NAN_BOX, sh[31:0]};
        else       res = {{(BUS_WIDTH-32){sh[31]}}, sh[31:0]};
      end
      LD:  res = sh;
      LBU: res = {{(BUS_WIDTH-8){1'b0}}, sh[7:0]};
      LHU: res = {{(BUS_WIDTH-16){1'b0}}, sh[15:0]};
      LWU: res = {{(BUS_WIDTH-32){1'b0}}, sh[31:0]};
      default: res = {BUS_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  assign w_pipe_req = mem_valid & mem_reg_write;
  assign fpu_ready  = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push     = fpu_valid & fpu_ready;
  assign w_pop      = ~w_pipe_req & ~w_empty;

  wb_result_fifo #(
    .DATA_W (BUS_WIDTH),
    .RD_W   (REGFILE_LEN),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_push_rd     (fpu_rd),
    .i_push_data   (fpu_result),
    .o_head_rd     (w_head_rd),
    .o_head_data   (w_head_data),
    .o_count       (w_count),
    .o_empty       (w_empty),
    .o_entry_valid (w_entry_valid),
    .o_entry_rd    (w_entry_rd)
  );

  always_comb begin
    w_sel      = 1'b0;
    w_sel_rd   = r_wb_rd;
    w_sel_data = r_wb_data;
    if (w_pipe_req) begin
      w_sel    = 1'b1;
      w_sel_rd = mem_rd;
      if (mem_to_reg) w_sel_data = f_load_extract(mem_funct3, mem_addr_lo, mem_rd[FP_BANK_BIT], mem_read_data);
      else            w_sel_data = mem_alu_result;
    end else if (w_pop) begin
      w_sel      = 1'b1;
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
    end else begin
      w_sel = 1'b0;
    end
  end

  always_comb begin
    w_pending = {PM_W{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i]) w_pending[w_entry_rd[i*REGFILE_LEN +: REGFILE_LEN]] = 1'b1;
      else                  w_pending = w_pending;
    end
  end

  // x0 writes still consume the slot but never assert the enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= {REGFILE_LEN{1'b0}};
      r_wb_data      <= {BUS_WIDTH{1'b0}};
    end else begin
      r_wb_reg_write <= w_sel & (w_sel_rd != {REGFILE_LEN{1'b0}});
      r_wb_rd        <= w_sel_rd;
      r_wb_data      <= w_sel_data;
    end
  end

  assign wb_reg_write  = r_wb_reg_write;
  assign wb_rd         = r_wb_rd;
  assign wb_write_data = r_wb_data;
  assign pending_mask  = w_pending;
  assign fifo_empty    = w_empty;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, load extraction, priority, push/pop overlap,
// x0 suppression and duplicate destinations, with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_reg_write, mem_to_reg;
  logic [2:0]  mem_funct3, mem_addr_lo;
  logic [5:0]  mem_rd;
  logic [63:0] mem_alu_result, mem_read_data;
  logic        fpu_valid, fpu_ready;
  logic [5:0]  fpu_rd;
  logic [63:0] fpu_result;
  logic        wb_reg_write;
  logic [5:0]  wb_rd;
  logic [63:0] wb_write_data;
  logic [63:0] pending_mask;
  logic        fifo_empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_result(fpu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
    .pending_mask(pending_mask), .fifo_empty(fifo_empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_to_reg = 1'b0;
    mem_funct3 = 3'b000; mem_addr_lo = 3'b000; mem_rd = 6'h00;
    mem_alu_result = 64'h0; mem_read_data = 64'h0;
    fpu_valid = 1'b0; fpu_rd = 6'h00; fpu_result = 64'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b exp 1", fifo_empty); end
    n_tests++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", fpu_ready); end
    n_tests++; if (pending_mask !== 64'h0) begin n_fail++; $display("FAIL rst_pending: got %h exp 0", pending_mask); end
    n_tests++; if (wb_reg_write !== 1'b0 || wb_rd !== 6'h00 || wb_write_data !== 64'h0) begin
      n_fail++; $display("FAIL rst_wb: got we=%b rd=%h d=%h exp 0/0/0", wb_reg_write, wb_rd, wb_write_data); end
    // fill three entries while the pipeline holds the port
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 6'h01; mem_alu_result = 64'h11;
    fpu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fpu_rd = 6'h21 + 6'(i); fpu_result = 64'hC0 + 64'(i);
      step();
    end
    fpu_valid = 1'b0;
    n_tests++; if (pending_mask !== 64'h0000_000E_0000_0000) begin n_fail++; $display("FAIL mid_pending: got %h exp 0000000e00000000", pending_mask); end
    mem_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b exp 1", fifo_empty); end
    n_tests++; if (pending_mask !== 64'h0) begin n_fail++; $display("FAIL midrst_pending: got %h exp 0", pending_mask); end
    n_tests++; if (wb_reg_write !== 1'b0 || wb_rd !== 6'h00) begin n_fail++; $display("FAIL midrst_wb: got we=%b rd=%h exp 0/00", wb_reg_write, wb_rd); end
    n_tests++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b exp 1", fpu_ready); end
    step();
    n_tests++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL midrst_drain: got we=%b exp 0", wb_reg_write); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  t_f3  [13] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b000, 3'b110,
                                3'b101, 3'b011, 3'b111, 3'b010, 3'b010, 3'b001};
    logic [2:0]  t_off [13] = '{3'd3, 3'd6, 3'd4, 3'd4, 3'd7, 3'd7, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    logic [5:0]  t_rd  [13] = '{6'h05, 6'h06, 6'h25, 6'h07, 6'h08, 6'h09, 6'h0A,
                                6'h0B, 6'h0C, 6'h0D, 6'h26, 6'h0E, 6'h0F};
    logic [63:0] t_exp [13] = '{64'h0000_0000_0000_0044, 64'hFFFF_FFFF_FFFF_8877,
                                64'hFFFF_FFFF_8877_6655, 64'hFFFF_FFFF_8877_6655,
                                64'h0000_0000_0000_0088, 64'hFFFF_FFFF_FFFF_FF88,
                                64'h0000_0000_8877_6655, 64'h0000_0000_0000_2211,
                                64'h8877_6655_4433_2211, 64'h0000_0000_0000_0000,
                                64'hFFFF_FFFF_4433_2211, 64'h0000_0000_4433_2211,
                                64'h0000_0000_0000_4433};
    idle_inputs();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_to_reg = 1'b1;
    mem_read_data = 64'h8877_6655_4433_2211;
    for (int i = 0; i < 13; i++) begin
      mem_funct3 = t_f3[i]; mem_addr_lo = t_off[i]; mem_rd = t_rd[i];
      step();
      n_tests++; if (wb_write_data !== t_exp[i] || wb_rd !== t_rd[i] || wb_reg_write !== 1'b1) begin
        n_fail++; $display("FAIL load_%0d: got we=%b rd=%h d=%h exp 1/%h/%h", i, wb_reg_write, wb_rd, wb_write_data, t_rd[i], t_exp[i]); end
    end
    mem_to_reg = 1'b0; mem_rd = 6'h09; mem_alu_result = 64'h0000_0000_DEAD_BEEF;
    step();
    n_tests++; if (wb_write_data !== 64'h0000_0000_DEAD_BEEF) begin n_fail++; $display("FAIL alu_path: got %h exp 00000000deadbeef", wb_write_data); end
    idle_inputs();
    step();
  endtask

  task automatic test_priority();
    logic [5:0]  e_rd;
    logic [63:0] e_d;
    logic        e_rdy;
    idle_inputs();
    mem_valid = 1'b1; mem_reg_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_rd = 6'h01 + 6'(i); mem_alu_result = 64'h100 + 64'(i);
      fpu_valid = (i < 4); fpu_rd = 6'h21 + 6'(i); fpu_result = 64'hF000 + 64'(i);
      step();
      e_rd = 6'h01 + 6'(i); e_rdy = (i < 3);
      n_tests++; if (wb_reg_write !== 1'b1 || wb_rd !== e_rd) begin n_fail++; $display("FAIL prio_pipe_%0d: got we=%b rd=%h exp 1/%h", i, wb_reg_write, wb_rd, e_rd); end
      n_tests++; if (fpu_ready !== e_rdy) begin n_fail++; $display("FAIL prio_ready_%0d: got %b exp %b", i, fpu_ready, e_rdy); end
    end
    n_tests++; if (pending_mask !== 64'h0000_001E_0000_0000) begin n_fail++; $display("FAIL prio_pending: got %h exp 0000001e00000000", pending_mask); end
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      step();
      e_rd = 6'h21 + 6'(j); e_d = 64'hF000 + 64'(j);
      n_tests++; if (wb_reg_write !== 1'b1 || wb_rd !== e_rd || wb_write_data !== e_d) begin
        n_fail++; $display("FAIL prio_drain_%0d: got we=%b rd=%h d=%h exp 1/%h/%h", j, wb_reg_write, wb_rd, wb_write_data, e_rd, e_d); end
    end
    n_tests++; if (fpu_ready !== 1'b1 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL prio_empty: got rdy=%b empty=%b exp 1/1", fpu_ready, fifo_empty); end
    step();
    n_tests++; if (wb_reg_write !== 1'b0 || wb_rd !== 6'h24 || wb_write_data !== 64'hF003) begin
      n_fail++; $display("FAIL prio_hold: got we=%b rd=%h d=%h exp 0/24/f003", wb_reg_write, wb_rd, wb_write_data); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 6'h07; mem_alu_result = 64'h77;
    fpu_valid = 1'b1; fpu_rd = 6'h30; fpu_result = 64'hA30;
    step();
    fpu_rd = 6'h31; fpu_result = 64'hA31;
    step();
    mem_valid = 1'b0; fpu_rd = 6'h32; fpu_result = 64'hA32;
    step();
    fpu_valid = 1'b0;
    n_tests++; if (wb_reg_write !== 1'b1 || wb_rd !== 6'h30 || wb_write_data !== 64'hA30) begin
      n_fail++; $display("FAIL pp_head: got we=%b rd=%h d=%h exp 1/30/a30", wb_reg_write, wb_rd, wb_write_data); end
    n_tests++; if (pending_mask !== 64'h0006_0000_0000_0000) begin n_fail++; $display("FAIL pp_pending: got %h exp 0006000000000000", pending_mask); end
    n_tests++; if (fifo_empty !== 1'b0 || fpu_ready !== 1'b1) begin n_fail++; $display("FAIL pp_state: got empty=%b rdy=%b exp 0/1", fifo_empty, fpu_ready); end
    step();
    n_tests++; if (wb_rd !== 6'h31 || wb_write_data !== 64'hA31) begin n_fail++; $display("FAIL pp_second: got rd=%h d=%h exp 31/a31", wb_rd, wb_write_data); end
    step();
    n_tests++; if (wb_rd !== 6'h32 || wb_write_data !== 64'hA32 || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL pp_third: got rd=%h d=%h empty=%b exp 32/a32/1", wb_rd, wb_write_data, fifo_empty); end
  endtask

  task automatic test_x0();
    idle_inputs();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 6'h00; mem_alu_result = 64'h55;
    step();
    n_tests++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_pipe: got we=%b exp 0", wb_reg_write); end
    idle_inputs();
    fpu_valid = 1'b1; fpu_rd = 6'h20; fpu_result = 64'hF0F0;
    step();
    fpu_valid = 1'b0;
    n_tests++; if (wb_reg_write !== 1'b0 || fifo_empty !== 1'b0 || pending_mask !== 64'h0000_0001_0000_0000) begin
      n_fail++; $display("FAIL x0_nobypass: got we=%b empty=%b pm=%h exp 0/0/0000000100000000", wb_reg_write, fifo_empty, pending_mask); end
    step();
    n_tests++; if (wb_reg_write !== 1'b1 || wb_rd !== 6'h20 || wb_write_data !== 64'hF0F0) begin
      n_fail++; $display("FAIL x0_f0: got we=%b rd=%h d=%h exp 1/20/f0f0", wb_reg_write, wb_rd, wb_write_data); end
    fpu_valid = 1'b1; fpu_rd = 6'h00; fpu_result = 64'h1234;
    step();
    fpu_valid = 1'b0;
    step();
    n_tests++; if (wb_reg_write !== 1'b0 || wb_rd !== 6'h00 || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL x0_fpu: got we=%b rd=%h empty=%b exp 0/00/1", wb_reg_write, wb_rd, fifo_empty); end
  endtask

  task automatic test_duplicate_rd();
    idle_inputs();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 6'h03; mem_alu_result = 64'h33;
    fpu_valid = 1'b1; fpu_rd = 6'h28; fpu_result = 64'hAAAA;
    step();
    fpu_result = 64'hBBBB;
    step();
    idle_inputs();
    n_tests++; if (pending_mask !== 64'h0000_0100_0000_0000) begin n_fail++; $display("FAIL dup_pending: got %h exp 0000010000000000", pending_mask); end
    step();
    n_tests++; if (wb_write_data !== 64'hAAAA || pending_mask !== 64'h0000_0100_0000_0000) begin
      n_fail++; $display("FAIL dup_first: got d=%h pm=%h exp aaaa/0000010000000000", wb_write_data, pending_mask); end
    step();
    n_tests++; if (wb_rd !== 6'h28 || wb_write_data !== 64'hBBBB || pending_mask !== 64'h0) begin
      n_fail++; $display("FAIL dup_last: got rd=%h d=%h pm=%h exp 28/bbbb/0", wb_rd, wb_write_data, pending_mask); end
  endtask

  initial begin
    test_reset();
    test_load_extract();
    test_priority();
    test_back_to_back();
    test_x0();
    test_duplicate_rd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
